proc_irq_ctrl: RTL and testbench

Interrupt front-end directly upstream of `proc`. Buffers key and Ethernet events, each carrying a 32-bit payload, in per-source FIFOs. Presents one event at a time on `interrupt_key` / `interrupt_eth` / `interrupt_source_data`, and holds it until the core acknowledges entry into the handler and later signals handler completion. Ethernet has fixed priority over key. Events that arrive while a FIFO is full are counted and dropped.

---
 rtl/proc_irq_pkg.sv | 19 +
 rtl/irq_fifo.sv | 55 +++++
 rtl/proc_irq_ctrl.sv | 105 ++++++++++
 tb/tb_proc_irq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_irq_pkg.sv
// Shared types and constants for the proc interrupt front-end.
package proc_irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PEND    = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

  localparam logic SRC_KEY = 1'b0;
  localparam logic SRC_ETH = 1'b1;

  localparam int unsigned DROP_W = 8;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/irq_fifo.sv
// Per-source event FIFO; head is read combinationally, pointers advance on the edge.
module irq_fifo
  import proc_irq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/proc_irq_ctrl.sv
// Interrupt front-end for proc: buffers key/eth events, presents one at a time,
// eth has fixed priority over key.
module proc_irq_ctrl
  import proc_irq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  input  logic              eth_valid,
  input  logic [DATA_W-1:0] eth_data,
  input  logic [1:0]        irq_en,
  input  logic              irq_ack,
  input  logic              irq_done,
  output logic              interrupt_key,
  output logic              interrupt_eth,
  output logic [DATA_W-1:0] interrupt_source_data,
  output logic [DROP_W-1:0] key_drop_cnt,
  output logic [DROP_W-1:0] eth_drop_cnt,
  output logic              busy
);

  irq_state_t        state;
  logic              sel;
  logic              key_full, key_empty, eth_full, eth_empty;
  logic [DATA_W-1:0] key_head, eth_head;
  logic              pop_key, pop_eth;

  assign pop_key = (state == IRQ_PEND) && irq_ack && (sel == SRC_KEY);
  assign pop_eth = (state == IRQ_PEND) && irq_ack && (sel == SRC_ETH);
  assign busy    = (state != IRQ_IDLE);

  irq_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_key_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (key_valid),
    .push_data (key_data),
    .pop       (pop_key),
    .full      (key_full),
    .empty     (key_empty),
    .head_data (key_head)
  );

  irq_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_eth_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (eth_valid),
    .push_data (eth_data),
    .pop       (pop_eth),
    .full      (eth_full),
    .empty     (eth_empty),
    .head_data (eth_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IRQ_IDLE;
      sel                   <= SRC_KEY;
      interrupt_key         <= 1'b0;
      interrupt_eth         <= 1'b0;
      interrupt_source_data <= '0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (irq_en[1] && !eth_empty) begin
            state                 <= IRQ_PEND;
            sel                   <= SRC_ETH;
            interrupt_eth         <= 1'b1;
            interrupt_source_data <= eth_head;
          end else if (irq_en[0] && !key_empty) begin
            state                 <= IRQ_PEND;
            sel                   <= SRC_KEY;
            interrupt_key         <= 1'b1;
            interrupt_source_data <= key_head;
          end
        end
        IRQ_PEND: begin
          if (irq_ack) begin
            state         <= IRQ_SERVICE;
            interrupt_key <= 1'b0;
            interrupt_eth <= 1'b0;
          end
        end
        IRQ_SERVICE: begin
          if (irq_done) state <= IRQ_IDLE;
        end
        default: state <= IRQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_drop_cnt <= '0;
      eth_drop_cnt <= '0;
    end else begin
      if (key_valid && key_full && !pop_key) key_drop_cnt <= sat_inc(key_drop_cnt);
      if (eth_valid && eth_full && !pop_eth) eth_drop_cnt <= sat_inc(eth_drop_cnt);
    end
  end

endmodule

// File: tb/tb_proc_irq_ctrl.sv
// Scoreboard bench for proc_irq_ctrl: stimulus queues expected interrupts, a monitor checks each one presented.
module tb_proc_irq_ctrl;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid, eth_valid;
  logic [31:0] key_data, eth_data;
  logic [1:0]  irq_en;
  logic        irq_ack, irq_done;
  logic        interrupt_key, interrupt_eth;
  logic [31:0] interrupt_source_data;
  logic [7:0]  key_drop_cnt, eth_drop_cnt;
  logic        busy;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic prev_k = 1'b0, prev_e = 1'b0;

  always #5 clk = ~clk;

  proc_irq_ctrl #(.DEPTH(4), .DATA_W(32)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .key_valid             (key_valid),
    .key_data              (key_data),
    .eth_valid             (eth_valid),
    .eth_data              (eth_data),
    .irq_en                (irq_en),
    .irq_ack               (irq_ack),
    .irq_done              (irq_done),
    .interrupt_key         (interrupt_key),
    .interrupt_eth         (interrupt_eth),
    .interrupt_source_data (interrupt_source_data),
    .key_drop_cnt          (key_drop_cnt),
    .eth_drop_cnt          (eth_drop_cnt),
    .busy                  (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every rising interrupt line must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (interrupt_key || interrupt_eth)
        chk("one_line_only", {31'd0, interrupt_key && interrupt_eth}, 32'd0);
      if ((interrupt_key && !prev_k) || (interrupt_eth && !prev_e)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_irq", {31'd0, interrupt_eth}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("irq_src", {31'd0, interrupt_eth}, {31'd0, e.src});
          chk("irq_data", interrupt_source_data, e.data);
        end
      end
    end
    prev_k = interrupt_key;
    prev_e = interrupt_eth;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic k, input logic [31:0] kd, input logic e, input logic [31:0] ed);
    key_valid = k; key_data = kd;
    eth_valid = e; eth_data = ed;
    tick();
    key_valid = 1'b0;
    eth_valid = 1'b0;
  endtask

  task automatic ack_done();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    int unsigned n = 0;
    while (!(interrupt_key || interrupt_eth) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk(name, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_valid = 1'b0; eth_valid = 1'b0;
    key_data = '0; eth_data = '0;
    irq_en = 2'b11; irq_ack = 1'b0; irq_done = 1'b0;
    tick(); tick();
    chk("rst_key", {31'd0, interrupt_key}, 32'd0);
    chk("rst_eth", {31'd0, interrupt_eth}, 32'd0);
    chk("rst_data", interrupt_source_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_drops", {16'd0, key_drop_cnt, eth_drop_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Single key event and latency
    exp_q.push_back('{src: 1'b0, data: 32'hDEAD_BEEF});
    strobe(1'b1, 32'hDEAD_BEEF, 1'b0, '0);
    chk("lat_edge_k", {31'd0, interrupt_key}, 32'd0);
    tick();
    chk("lat_edge_k1", {31'd0, interrupt_key}, 32'd1);
    chk("single_data", interrupt_source_data, 32'hDEAD_BEEF);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ack_line_low", {31'd0, interrupt_key}, 32'd0);
    chk("ack_busy", {31'd0, busy}, 32'd1);
    chk("svc_data_held", interrupt_source_data, 32'hDEAD_BEEF);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    chk("done_busy", {31'd0, busy}, 32'd0);
    tick();

    // Priority: eth before key
    exp_q.push_back('{src: 1'b1, data: 32'h22});
    exp_q.push_back('{src: 1'b0, data: 32'h11});
    strobe(1'b1, 32'h11, 1'b1, 32'h22);
    tick();
    chk("prio_eth_line", {31'd0, interrupt_eth}, 32'd1);
    ack_done();
    chk("gap_idle", {30'd0, interrupt_key, busy}, 32'd0);
    tick();
    chk("prio_key_line", {31'd0, interrupt_key}, 32'd1);
    chk("prio_key_data", interrupt_source_data, 32'h11);
    ack_done();
    tick();

    // Overflow: six key strobes without ack
    for (int i = 1; i <= 4; i++) exp_q.push_back('{src: 1'b0, data: 32'(i)});
    for (int i = 1; i <= 6; i++) strobe(1'b1, 32'(i), 1'b0, '0);
    chk("ovf_drop_cnt", {24'd0, key_drop_cnt}, 32'd2);
    chk("ovf_head", interrupt_source_data, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      wait_irq("ovf_drain_timeout");
      ack_done();
    end
    tick(); tick();
    chk("ovf_drained_idle", {31'd0, busy}, 32'd0);

    // Mask: eth buffered while disabled
    irq_en = 2'b01;
    exp_q.push_back('{src: 1'b1, data: 32'h5A});
    strobe(1'b0, '0, 1'b1, 32'h5A);
    tick(); tick();
    chk("mask_no_eth", {30'd0, interrupt_eth, busy}, 32'd0);
    irq_en = 2'b11;
    tick();
    chk("unmask_eth", {31'd0, interrupt_eth}, 32'd1);
    irq_en = 2'b00;
    tick();
    chk("pend_held", {31'd0, interrupt_eth}, 32'd1);
    irq_en = 2'b11;
    ack_done();
    tick();

    // Stray handshakes in IDLE
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    chk("stray_busy", {31'd0, busy}, 32'd0);

    // Reset in SERVICE with three events queued
    exp_q.push_back('{src: 1'b0, data: 32'hA1});
    for (int i = 1; i <= 4; i++) strobe(1'b1, 32'hA0 + 32'(i), 1'b0, '0);
    wait_irq("rst_setup_timeout");
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("mid_rst_outs", {29'd0, interrupt_key, interrupt_eth, busy}, 32'd0);
    chk("mid_rst_data", interrupt_source_data, 32'd0);
    chk("mid_rst_drops", {16'd0, key_drop_cnt, eth_drop_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("post_rst_quiet", {31'd0, busy}, 32'd0);

    exp_q.push_back('{src: 1'b1, data: 32'h77});
    strobe(1'b0, '0, 1'b1, 32'h77);
    wait_irq("post_rst_timeout");
    ack_done();
    for (int i = 0; i < 5; i++) tick();
    chk("final_idle", {31'd0, busy}, 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
